// File: rtl/hfu_pkg.sv
// Shared constants and helpers for the hazard/forwarding unit.
// Optional build macro: HFU_STALL_CNT_EN (adds the stall_cycles counter to the top).
package hfu_pkg;

    localparam int HFU_RA_W_DEF  = 5;
    localparam int HFU_N_FWD_DEF = 2;
    localparam int HFU_LAT_W_DEF = 3;

    // Forward select value meaning "take the operand from the register file".
    localparam int FWD_SEL_RF = 0;

    // Source i (0 = youngest) is encoded as n-i so the youngest gets the largest code.
    function automatic int fwd_enc(input int i, input int n);
        return n - i;
    endfunction

endpackage

// File: rtl/hfu_scoreboard.sv
// Per-register busy countdown for multi-cycle results, with the two ID-stage busy lookups.
// Update priority per edge: reset/flush clear, then issue load, then decrement.
module hfu_scoreboard
    import hfu_pkg::*;
#(
    parameter int RA_W  = HFU_RA_W_DEF,
    parameter int LAT_W = HFU_LAT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_issue,
    input  logic [RA_W-1:0]  i_issue_rd,
    input  logic [LAT_W-1:0] i_issue_lat,
    input  logic [RA_W-1:0]  i_rs1,
    input  logic [RA_W-1:0]  i_rs2,
    output logic             o_busy1,
    output logic             o_busy2
);

    localparam int NREGS = 2 ** RA_W;

    logic [LAT_W-1:0] r_cnt [NREGS];
    logic             w_mark;

    // x0 is never marked and single-cycle ops (latency 0) leave the entry alone.
    assign w_mark = i_issue && (i_issue_rd != '0) && (i_issue_lat != '0);

    always_ff @(posedge i_clk) begin
        for (int r = 0; r < NREGS; r++) begin
            if (i_rst || i_flush) begin
                r_cnt[r] <= '0;
            end else if (w_mark && (i_issue_rd == RA_W'(r))) begin
                r_cnt[r] <= i_issue_lat;
            end else if (r_cnt[r] != '0) begin
                r_cnt[r] <= r_cnt[r] - 1'b1;
            end
        end
    end

    assign o_busy1 = (r_cnt[i_rs1] != '0);
    assign o_busy2 = (r_cnt[i_rs2] != '0);

endmodule

// File: rtl/hazard_fwd_unit.sv
// N-source operand forwarding plus load-use and scoreboard stall generation.
// Optional build macro: HFU_STALL_CNT_EN adds a saturating stall_cycles counter port.
module hazard_fwd_unit
    import hfu_pkg::*;
#(
    parameter int RA_W  = HFU_RA_W_DEF,
    parameter int N_FWD = HFU_N_FWD_DEF,
    parameter int LAT_W = HFU_LAT_W_DEF,
    parameter int SEL_W = $clog2(N_FWD + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_FWD-1:0]      fwd_wen,
    input  logic [N_FWD*RA_W-1:0] fwd_rd,
    input  logic [RA_W-1:0]       ex_rs1,
    input  logic [RA_W-1:0]       ex_rs2,
    output logic [SEL_W-1:0]      forwardA,
    output logic [SEL_W-1:0]      forwardB,
    input  logic [RA_W-1:0]       id_rs1,
    input  logic [RA_W-1:0]       id_rs2,
    input  logic                  id_use1,
    input  logic                  id_use2,
    input  logic                  ex_is_load,
    input  logic                  ex_wen,
    input  logic [RA_W-1:0]       ex_rd,
    input  logic                  issue,
    input  logic [RA_W-1:0]       issue_rd,
    input  logic [LAT_W-1:0]      issue_lat,
    input  logic                  flush,
    output logic                  stall
`ifdef HFU_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    logic [SEL_W-1:0] w_fwd_a;
    logic [SEL_W-1:0] w_fwd_b;
    logic             w_busy1;
    logic             w_busy2;
    logic             w_load_use;
    logic             w_sb_hazard;

    // Walk oldest to youngest so the youngest matching source is written last and wins.
    always_comb begin
        w_fwd_a = SEL_W'(FWD_SEL_RF);
        w_fwd_b = SEL_W'(FWD_SEL_RF);
        for (int i = N_FWD - 1; i >= 0; i--) begin
            if (fwd_wen[i] && (fwd_rd[i*RA_W +: RA_W] != '0)) begin
                if (fwd_rd[i*RA_W +: RA_W] == ex_rs1) begin
                    w_fwd_a = SEL_W'(fwd_enc(i, N_FWD));
                end
                if (fwd_rd[i*RA_W +: RA_W] == ex_rs2) begin
                    w_fwd_b = SEL_W'(fwd_enc(i, N_FWD));
                end
            end
        end
    end

    assign forwardA = rst ? SEL_W'(FWD_SEL_RF) : w_fwd_a;
    assign forwardB = rst ? SEL_W'(FWD_SEL_RF) : w_fwd_b;

    // The bubble pushes the load out of EX, so this clears itself after one cycle.
    assign w_load_use = ex_is_load && ex_wen && (ex_rd != '0) &&
                        ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd)));

    hfu_scoreboard #(
        .RA_W  (RA_W),
        .LAT_W (LAT_W)
    ) u_scoreboard (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (flush),
        .i_issue     (issue),
        .i_issue_rd  (issue_rd),
        .i_issue_lat (issue_lat),
        .i_rs1       (id_rs1),
        .i_rs2       (id_rs2),
        .o_busy1     (w_busy1),
        .o_busy2     (w_busy2)
    );

    assign w_sb_hazard = (id_use1 && (id_rs1 != '0) && w_busy1) ||
                         (id_use2 && (id_rs2 != '0) && w_busy2);

    // Handshake: stall=1 means the ID instruction may not advance; control keeps issue low
    // while stall is high, but an issue seen under stall is still recorded in the scoreboard.
    assign stall = !rst && (w_load_use || w_sb_hazard);

`ifdef HFU_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
